hpdcache_mem_responder: RTL and testbench
=========================================

# hpdcache_mem_responder

Memory-side responder for the HPDcache memory interface. It accepts the cache's read and write requests, which carry 32-bit addresses, 6-bit IDs and 32-bit data. It serves them as bursts against one single-port on-chip SRAM (BRAM/SPRAM) with byte enables, and returns read-data beats and write acknowledgements. It sits between the HPDcache memory ports and the ice40up5k backing RAM.

## Interface
- MEM_ADDR_W, 32, byte-address width
- MEM_ID_W, 6, transaction ID width
- MEM_DATA_W, 32, beat width (fixed to 32)
- MEM_WORDS, 4096, SRAM depth in 32-bit words; SA_W = $clog2(MEM_WORDS)
- BASE_ADDR, 0, byte address mapped to SRAM word 0

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- mem_req_read_valid_i / mem_req_read_ready_o  in/out  1  read-request handshake
- mem_req_read_addr_i, _len_i, _size_i, _id_i, _command_i  in  32/8/3/6/2  read request fields; len = beats-1
- mem_resp_read_valid_o / mem_resp_read_ready_i  out/in  1  read-response handshake
- mem_resp_read_error_o, _id_o, _data_o, _last_o  out  2/6/32/1  read beat
- mem_req_write_valid_i / mem_req_write_ready_o  in/out  1  write-request handshake
- mem_req_write_addr_i, _len_i, _size_i, _id_i, _command_i  in  32/8/3/6/2  write request fields
- mem_req_write_data_valid_i / mem_req_write_data_ready_o  in/out  1  write-data handshake
- mem_req_write_data_i, _be_i, _last_i  in  32/4/1  write beat
- mem_resp_write_valid_o / mem_resp_write_ready_i  out/in  1  write-ack handshake
- mem_resp_write_error_o, _id_o, _is_atomic_o  out  2/6/1  write ack
- sram_en_o, sram_we_o  out  1  SRAM access strobe and write enable
- sram_addr_o  out  SA_W  word address
- sram_wdata_o, sram_be_o  out  32/4  write data and byte enables
- sram_rdata_i  in  32  read data, 1-cycle latency, held stable while sram_en_o=0

## Operation
- Encodings: command READ=2'b00, WRITE=2'b01, ATOMIC=2'b10. Error OK=2'b00, NOK=2'b10. Handshake occurs when valid and ready are both 1.
- FSM states: IDLE, RD, WR_DATA, WR_RESP.
- IDLE: both request readies are 1, but only the arbitration winner is accepted.
  - If only one request is valid, that request wins.
  - If both are valid, round-robin decides; flag `rd_first` toggles after each grant. Reset value: read first. The loser's ready is 0.
- Accept: latch id, beat counter = len, word pointer = (addr - BASE_ADDR) >> 2 (addr[1:0] ignored), and err.
- err=1 when any of the following holds:
  - command is not READ (read channel) or not WRITE (write channel);
  - size > 3'd2;
  - addr < BASE_ADDR;
  - pointer + len >= MEM_WORDS, i.e. the burst overflows. No wrap-around.
- Read accept (err=0): issue SRAM read (en=1, we=0) in the accept cycle, then go to RD.
- RD:
  - resp_read_valid=1; data = sram_rdata_i (0 if err); error = err; id = latched id; last = (counter==0).
  - On a handshake with counter>0: decrement counter, increment pointer, issue the next SRAM read in that same cycle.
  - On a handshake with last=1: go to IDLE.
  - An erroneous read still returns len+1 beats, and none of them issues an SRAM access.
- Write accept: go to WR_DATA.
- WR_DATA:
  - write_data_ready=1.
  - Each beat handshake drives en=1, we=1, addr=pointer, wdata, be in the same cycle; no SRAM write if err.
  - Each beat decrements the counter and increments the pointer.
  - The beat count governs the end of the burst; mem_req_write_data_last_i is ignored. Write data presented in IDLE is not consumed.
  - The beat taken at counter==0 moves the FSM to WR_RESP.
- WR_RESP: resp_write_valid=1 with error=err, id = latched id, is_atomic=0. Hold until ready, then go to IDLE.
- Only one transaction is in flight at a time. No request is accepted outside IDLE.

## Timing
- Reset values: all valids 0, all readies 0 except the IDLE request readies (1 from the first cycle after reset). sram_en_o=0, sram_we_o=0, other outputs 0, state IDLE.
- Reset asserted mid-burst aborts the burst. Outstanding beats and acks are dropped and the FSM is in IDLE on the next cycle.
- Read: request accepted at cycle T gives the first beat valid at T+1. With ready held at 1, bursts stream at 1 beat/cycle and the last beat is at T+1+len. Backpressure stalls the beat with data held, because the SRAM output is stable while en=0.
- Write: accept at T, first data beat acceptable at T+1. With data streaming, the ack is valid the cycle after the final beat.
- A new request can be accepted the cycle after the final read handshake or the ack handshake.

## Test plan
- Read burst: write words 0..7 to SRAM, then read addr=0x0, len=7, id=5, ready=1 → 8 beats on consecutive cycles, data matches, id=5, last only on beat 8, error OK.
- Write with byte enables: addr=0x10, len=0, data=0xAABBCCDD, be=4'b0101 → SRAM word 4 updates only bytes 0 and 2; ack id matches, error OK, 1 cycle after the beat.
- Backpressure: read len=3 with resp ready toggling 1,0,0,1… → data stable while stalled, exactly 4 handshakes, no SRAM read while stalled.
- Errors, each acked with NOK and no SRAM write:
  - read at pointer MEM_WORDS-2 with len=3 → 4 beats, data 0, all NOK;
  - write command=ATOMIC on the write channel;
  - write size=3'd3.
- Arbitration: read and write valid in the same cycle twice → read granted first, write granted second; the second collision after the write goes to the read.
- Reset mid-burst: assert rst_i during beat 3 of a len=7 read → next cycle valid=0, state IDLE, a fresh read completes correctly.

Source files
------------

// File: rtl/hpdcache_mem_responder.sv
// HPDcache memory-side responder.
// Serves read/write bursts from one single-port SRAM.
module hpdcache_mem_responder #(
  parameter int unsigned MEM_ADDR_W = 32,
  parameter int unsigned MEM_ID_W   = 6,
  parameter int unsigned MEM_DATA_W = 32,
  parameter int unsigned MEM_WORDS  = 4096,
  parameter int unsigned SA_W       = $clog2(MEM_WORDS),
  parameter logic [MEM_ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    mem_req_read_valid_i,
  output logic                    mem_req_read_ready_o,
  input  logic [MEM_ADDR_W-1:0]   mem_req_read_addr_i,
  input  logic [7:0]              mem_req_read_len_i,
  input  logic [2:0]              mem_req_read_size_i,
  input  logic [MEM_ID_W-1:0]     mem_req_read_id_i,
  input  logic [1:0]              mem_req_read_command_i,

  output logic                    mem_resp_read_valid_o,
  input  logic                    mem_resp_read_ready_i,
  output logic [1:0]              mem_resp_read_error_o,
  output logic [MEM_ID_W-1:0]     mem_resp_read_id_o,
  output logic [MEM_DATA_W-1:0]   mem_resp_read_data_o,
  output logic                    mem_resp_read_last_o,

  input  logic                    mem_req_write_valid_i,
  output logic                    mem_req_write_ready_o,
  input  logic [MEM_ADDR_W-1:0]   mem_req_write_addr_i,
  input  logic [7:0]              mem_req_write_len_i,
  input  logic [2:0]              mem_req_write_size_i,
  input  logic [MEM_ID_W-1:0]     mem_req_write_id_i,
  input  logic [1:0]              mem_req_write_command_i,

  input  logic                    mem_req_write_data_valid_i,
  output logic                    mem_req_write_data_ready_o,
  input  logic [MEM_DATA_W-1:0]   mem_req_write_data_i,
  input  logic [MEM_DATA_W/8-1:0] mem_req_write_be_i,
  input  logic                    mem_req_write_last_i,

  output logic                    mem_resp_write_valid_o,
  input  logic                    mem_resp_write_ready_i,
  output logic [1:0]              mem_resp_write_error_o,
  output logic [MEM_ID_W-1:0]     mem_resp_write_id_o,
  output logic                    mem_resp_write_is_atomic_o,

  output logic                    sram_en_o,
  output logic                    sram_we_o,
  output logic [SA_W-1:0]         sram_addr_o,
  output logic [MEM_DATA_W-1:0]   sram_wdata_o,
  output logic [MEM_DATA_W/8-1:0] sram_be_o,
  input  logic [MEM_DATA_W-1:0]   sram_rdata_i
);

  localparam logic [1:0] CMD_READ  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_NOK   = 2'b10;
  localparam logic [MEM_ADDR_W:0] WORDS_X =
    (MEM_ADDR_W+1)'(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR_DATA,
    WR_RESP
  } state_t;

  state_t              state_q, state_d;
  logic                rd_first_q, rd_first_d;
  logic [MEM_ID_W-1:0] id_q, id_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [SA_W-1:0]     ptr_q, ptr_d;
  logic                err_q, err_d;

  logic                rd_err, wr_err;
  logic [SA_W-1:0]     rd_ptr, wr_ptr;
  logic                both_v;
  logic                rd_grant, wr_grant;
  logic                unused_last;

  assign unused_last = mem_req_write_last_i;

  function automatic logic req_err(
    input logic [MEM_ADDR_W-1:0] addr,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic                  cmd_ok
  );
    logic [MEM_ADDR_W:0] off;
    logic [MEM_ADDR_W:0] top;
    off = {1'b0, addr - BASE_ADDR} >> 2;
    top = off + {{(MEM_ADDR_W-7){1'b0}}, len};
    return !cmd_ok
        || (size > 3'd2)
        || (addr < BASE_ADDR)
        || (top >= WORDS_X);
  endfunction

  assign rd_err = req_err(
    mem_req_read_addr_i,
    mem_req_read_len_i,
    mem_req_read_size_i,
    mem_req_read_command_i == CMD_READ);
  assign wr_err = req_err(
    mem_req_write_addr_i,
    mem_req_write_len_i,
    mem_req_write_size_i,
    mem_req_write_command_i == CMD_WRITE);

  assign rd_ptr =
    SA_W'((mem_req_read_addr_i - BASE_ADDR) >> 2);
  assign wr_ptr =
    SA_W'((mem_req_write_addr_i - BASE_ADDR) >> 2);

  assign both_v = mem_req_read_valid_i
               && mem_req_write_valid_i;
  assign rd_grant = mem_req_read_valid_i
                 && !(both_v && !rd_first_q);
  assign wr_grant = mem_req_write_valid_i
                 && !(both_v && rd_first_q);

  // Next-state, datapath updates and all outputs.
  always_comb begin
    state_d    = state_q;
    rd_first_d = rd_first_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    err_d      = err_q;

    mem_req_read_ready_o       = 1'b0;
    mem_req_write_ready_o      = 1'b0;
    mem_req_write_data_ready_o = 1'b0;
    mem_resp_read_valid_o      = 1'b0;
    mem_resp_read_error_o      = ERR_OK;
    mem_resp_read_id_o         = '0;
    mem_resp_read_data_o       = '0;
    mem_resp_read_last_o       = 1'b0;
    mem_resp_write_valid_o     = 1'b0;
    mem_resp_write_error_o     = ERR_OK;
    mem_resp_write_id_o        = '0;
    mem_resp_write_is_atomic_o = 1'b0;
    sram_en_o                  = 1'b0;
    sram_we_o                  = 1'b0;
    sram_addr_o                = '0;
    sram_wdata_o               = '0;
    sram_be_o                  = '0;

    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          mem_req_read_ready_o  = !(both_v && !rd_first_q);
          mem_req_write_ready_o = !(both_v && rd_first_q);
          if (rd_grant) begin
            state_d    = RD;
            rd_first_d = ~rd_first_q;
            id_d       = mem_req_read_id_i;
            cnt_d      = mem_req_read_len_i;
            ptr_d      = rd_ptr;
            err_d      = rd_err;
            sram_en_o  = !rd_err;
            sram_addr_o = rd_err ? '0 : rd_ptr;
          end else if (wr_grant) begin
            state_d    = WR_DATA;
            rd_first_d = ~rd_first_q;
            id_d       = mem_req_write_id_i;
            cnt_d      = mem_req_write_len_i;
            ptr_d      = wr_ptr;
            err_d      = wr_err;
          end
        end
        RD: begin
          mem_resp_read_valid_o = 1'b1;
          mem_resp_read_error_o = err_q ? ERR_NOK : ERR_OK;
          mem_resp_read_id_o    = id_q;
          mem_resp_read_data_o  = err_q ? '0 : sram_rdata_i;
          mem_resp_read_last_o  = (cnt_q == 8'd0);
          if (mem_resp_read_ready_i) begin
            if (cnt_q == 8'd0) begin
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q - 8'd1;
              ptr_d = ptr_q + 1'b1;
              if (!err_q) begin
                sram_en_o   = 1'b1;
                sram_addr_o = ptr_q + 1'b1;
              end
            end
          end
        end
        WR_DATA: begin
          mem_req_write_data_ready_o = 1'b1;
          if (mem_req_write_data_valid_i) begin
            if (!err_q) begin
              sram_en_o    = 1'b1;
              sram_we_o    = 1'b1;
              sram_addr_o  = ptr_q;
              sram_wdata_o = mem_req_write_data_i;
              sram_be_o    = mem_req_write_be_i;
            end
            if (cnt_q == 8'd0) begin
              state_d = WR_RESP;
            end else begin
              cnt_d = cnt_q - 8'd1;
              ptr_d = ptr_q + 1'b1;
            end
          end
        end
        WR_RESP: begin
          mem_resp_write_valid_o = 1'b1;
          mem_resp_write_error_o = err_q ? ERR_NOK : ERR_OK;
          mem_resp_write_id_o    = id_q;
          if (mem_resp_write_ready_i) begin
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  // State and transaction context registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rd_first_q <= 1'b1;
      id_q       <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_first_q <= rd_first_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_hpdcache_mem_responder.sv
// Directed bench for hpdcache_mem_responder.
// Includes a behavioural single-port SRAM.
module tb_hpdcache_mem_responder;

  localparam int WORDS = 4096;
  localparam int SA_W  = 12;

  logic        clk = 1'b0;
  logic        rst;

  logic        rq_valid, rq_ready;
  logic [31:0] rq_addr;
  logic [7:0]  rq_len;
  logic [2:0]  rq_size;
  logic [5:0]  rq_id;
  logic [1:0]  rq_cmd;

  logic        rs_valid, rs_ready;
  logic [1:0]  rs_err;
  logic [5:0]  rs_id;
  logic [31:0] rs_data;
  logic        rs_last;

  logic        wq_valid, wq_ready;
  logic [31:0] wq_addr;
  logic [7:0]  wq_len;
  logic [2:0]  wq_size;
  logic [5:0]  wq_id;
  logic [1:0]  wq_cmd;

  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_be;
  logic        wd_last;

  logic        ws_valid, ws_ready;
  logic [1:0]  ws_err;
  logic [5:0]  ws_id;
  logic        ws_atomic;

  logic            sram_en, sram_we;
  logic [SA_W-1:0] sram_addr;
  logic [31:0]     sram_wdata;
  logic [3:0]      sram_be;
  logic [31:0]     srd = '0;

  logic [31:0] smem [0:WORDS-1];
  int en_cnt = 0;
  int we_cnt = 0;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hpdcache_mem_responder dut (
    .clk_i                      (clk),
    .rst_i                      (rst),
    .mem_req_read_valid_i       (rq_valid),
    .mem_req_read_ready_o       (rq_ready),
    .mem_req_read_addr_i        (rq_addr),
    .mem_req_read_len_i         (rq_len),
    .mem_req_read_size_i        (rq_size),
    .mem_req_read_id_i          (rq_id),
    .mem_req_read_command_i     (rq_cmd),
    .mem_resp_read_valid_o      (rs_valid),
    .mem_resp_read_ready_i      (rs_ready),
    .mem_resp_read_error_o      (rs_err),
    .mem_resp_read_id_o         (rs_id),
    .mem_resp_read_data_o       (rs_data),
    .mem_resp_read_last_o       (rs_last),
    .mem_req_write_valid_i      (wq_valid),
    .mem_req_write_ready_o      (wq_ready),
    .mem_req_write_addr_i       (wq_addr),
    .mem_req_write_len_i        (wq_len),
    .mem_req_write_size_i       (wq_size),
    .mem_req_write_id_i         (wq_id),
    .mem_req_write_command_i    (wq_cmd),
    .mem_req_write_data_valid_i (wd_valid),
    .mem_req_write_data_ready_o (wd_ready),
    .mem_req_write_data_i       (wd_data),
    .mem_req_write_be_i         (wd_be),
    .mem_req_write_last_i       (wd_last),
    .mem_resp_write_valid_o     (ws_valid),
    .mem_resp_write_ready_i     (ws_ready),
    .mem_resp_write_error_o     (ws_err),
    .mem_resp_write_id_o        (ws_id),
    .mem_resp_write_is_atomic_o (ws_atomic),
    .sram_en_o                  (sram_en),
    .sram_we_o                  (sram_we),
    .sram_addr_o                (sram_addr),
    .sram_wdata_o               (sram_wdata),
    .sram_be_o                  (sram_be),
    .sram_rdata_i               (srd)
  );

  // SRAM model: 1-cycle read, output held while idle.
  always @(posedge clk) begin
    if (sram_en) begin
      en_cnt <= en_cnt + 1;
      if (sram_we) begin
        we_cnt <= we_cnt + 1;
        for (int b = 0; b < 4; b++)
          if (sram_be[b])
            smem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        srd <= smem[sram_addr];
      end
    end
  end

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic rd_burst(
    input logic [31:0] addr,
    input logic [7:0]  len,
    input logic [5:0]  id,
    input logic [31:0] d0,
    input bit          err,
    input int          pat
  );
    int t, cyc, beat, en0;
    logic [31:0] exp_d;
    @(posedge clk); #1;
    rq_valid = 1'b1; rq_addr = addr; rq_len = len;
    rq_size = 3'd2; rq_cmd = 2'b00; rq_id = id;
    t = 0;
    @(negedge clk);
    while (!rq_ready && t < 20) begin
      @(negedge clk); t++;
    end
    check("rd_acc_wait", t < 20, 1);
    check("rd_acc_en", sram_en, !err);
    @(posedge clk); #1;
    rq_valid = 1'b0;
    en0 = en_cnt;
    beat = 0; cyc = 0;
    while (beat <= int'(len) && cyc < 200) begin
      rs_ready = (pat == 0) || (cyc % 3 == 0);
      @(negedge clk);
      exp_d = err ? 32'h0 : d0 + beat;
      check("rd_vld", rs_valid, 1);
      check("rd_data", rs_data, exp_d);
      if (rs_ready) begin
        check("rd_id", rs_id, id);
        check("rd_err", rs_err, err ? 2'b10 : 2'b00);
        check("rd_last", rs_last, beat == int'(len));
        beat++;
      end else begin
        check("rd_stall_en", sram_en, 0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("rd_beats", beat, len + 1);
    if (pat == 0) check("rd_cycles", cyc, len + 1);
    check("rd_sram_reads", en_cnt - en0, err ? 0 : len);
    rs_ready = 1'b1;
    @(negedge clk);
    check("rd_done_vld", rs_valid, 0);
  endtask

  task automatic wr_burst(
    input logic [31:0] addr,
    input logic [7:0]  len,
    input logic [2:0]  size,
    input logic [1:0]  cmd,
    input logic [5:0]  id,
    input logic [31:0] d0,
    input logic [3:0]  be,
    input bit          err
  );
    int t, w0;
    @(posedge clk); #1;
    wq_valid = 1'b1; wq_addr = addr; wq_len = len;
    wq_size = size; wq_cmd = cmd; wq_id = id;
    t = 0;
    @(negedge clk);
    while (!wq_ready && t < 20) begin
      @(negedge clk); t++;
    end
    check("wr_acc_wait", t < 20, 1);
    check("wr_acc_en", sram_en, 0);
    @(posedge clk); #1;
    wq_valid = 1'b0;
    w0 = we_cnt;
    for (int k = 0; k <= int'(len); k++) begin
      wd_valid = 1'b1; wd_data = d0 + k; wd_be = be;
      wd_last = (k == int'(len));
      @(negedge clk);
      check("wr_dready", wd_ready, 1);
      check("wr_we", sram_we, !err);
      @(posedge clk); #1;
    end
    wd_valid = 1'b0; wd_last = 1'b0;
    @(negedge clk);
    check("wr_ack_vld", ws_valid, 1);
    check("wr_ack_err", ws_err, err ? 2'b10 : 2'b00);
    check("wr_ack_id", ws_id, id);
    check("wr_ack_atomic", ws_atomic, 0);
    check("wr_sram_writes", we_cnt - w0, err ? 0 : len + 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("wr_ack_done", ws_valid, 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rq_valid = 0; rq_addr = 0; rq_len = 0; rq_size = 0;
    rq_id = 0; rq_cmd = 0; rs_ready = 1;
    wq_valid = 0; wq_addr = 0; wq_len = 0; wq_size = 0;
    wq_id = 0; wq_cmd = 0;
    wd_valid = 0; wd_data = 0; wd_be = 0; wd_last = 0;
    ws_ready = 1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_rrdy_in_rst", rq_ready, 0);
    check("rst_en_in_rst", sram_en, 0);
    do_reset(3);
    @(negedge clk);
    check("rst_rrdy", rq_ready, 1);
    check("rst_wrdy", wq_ready, 1);
    check("rst_wdrdy", wd_ready, 0);
    check("rst_rvld", rs_valid, 0);
    check("rst_wvld", ws_valid, 0);
    check("rst_en", sram_en, 0);
    check("rst_we", sram_we, 0);
    check("rst_state", 64'(dut.state_q), 0);

    wr_burst(32'h0, 8'd7, 3'd2, 2'b01, 6'd3,
             32'hC0DE_0000, 4'hF, 0);
    check("mem0", smem[0], 32'hC0DE_0000);
    check("mem7", smem[7], 32'hC0DE_0007);

    rd_burst(32'h0, 8'd7, 6'd5, 32'hC0DE_0000, 0, 0);
    rd_burst(32'h8, 8'd3, 6'd7, 32'hC0DE_0002, 0, 1);

    wr_burst(32'h10, 8'd0, 3'd2, 2'b01, 6'h11,
             32'hAABB_CCDD, 4'b0101, 0);
    check("mem4_be", smem[4], 32'hC0BB_00DD);
    rd_burst(32'h10, 8'd0, 6'd9, 32'hC0BB_00DD, 0, 0);

    rd_burst(32'h3FF8, 8'd3, 6'h2A, 32'h0, 1, 0);
    wr_burst(32'h14, 8'd0, 3'd2, 2'b10, 6'h21,
             32'hDEAD_BEEF, 4'hF, 1);
    check("mem5_keep", smem[5], 32'hC0DE_0005);
    wr_burst(32'h18, 8'd0, 3'd3, 2'b01, 6'h22,
             32'hDEAD_BEEF, 4'hF, 1);
    check("mem6_keep", smem[6], 32'hC0DE_0006);

    @(posedge clk); #1;
    rq_valid = 1; rq_addr = 32'h0; rq_len = 8'd7;
    rq_size = 3'd2; rq_cmd = 2'b00; rq_id = 6'd4;
    rs_ready = 1;
    @(negedge clk);
    check("mrst_acc", rq_ready, 1);
    @(posedge clk); #1;
    rq_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mrst_b3_vld", rs_valid, 1);
    check("mrst_b3_data", rs_data, 32'hC0DE_0002);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mrst_vld", rs_valid, 0);
    check("mrst_state", 64'(dut.state_q), 0);
    check("mrst_rrdy", rq_ready, 1);
    rd_burst(32'h4, 8'd1, 6'd8, 32'hC0DE_0001, 0, 0);

    do_reset(2);
    @(posedge clk); #1;
    rq_valid = 1; rq_addr = 32'h0; rq_len = 8'd0;
    rq_size = 3'd2; rq_cmd = 2'b00; rq_id = 6'd1;
    wq_valid = 1; wq_addr = 32'h40; wq_len = 8'd0;
    wq_size = 3'd2; wq_cmd = 2'b01; wq_id = 6'd2;
    @(negedge clk);
    check("arb1_rrdy", rq_ready, 1);
    check("arb1_wrdy", wq_ready, 0);
    @(posedge clk); #1;
    rq_valid = 0;
    @(negedge clk);
    check("arb1_rvld", rs_valid, 1);
    check("arb1_rid", rs_id, 6'd1);
    check("arb1_rdata", rs_data, 32'hC0DE_0000);
    check("arb1_wrdy_busy", wq_ready, 0);
    @(posedge clk); #1;
    rq_valid = 1;
    @(negedge clk);
    check("arb2_wrdy", wq_ready, 1);
    check("arb2_rrdy", rq_ready, 0);
    @(posedge clk); #1;
    wq_valid = 0;
    wd_valid = 1; wd_data = 32'h1234_5678; wd_be = 4'hF;
    @(negedge clk);
    check("arb2_wdrdy", wd_ready, 1);
    check("arb2_rrdy_busy", rq_ready, 0);
    @(posedge clk); #1;
    wd_valid = 0;
    @(negedge clk);
    check("arb2_ack", ws_valid, 1);
    check("arb2_ack_id", ws_id, 6'd2);
    @(posedge clk); #1;
    wq_valid = 1;
    @(negedge clk);
    check("arb3_rrdy", rq_ready, 1);
    check("arb3_wrdy", wq_ready, 0);
    @(posedge clk); #1;
    rq_valid = 0; wq_valid = 0;
    @(negedge clk);
    check("arb3_rvld", rs_valid, 1);
    check("arb3_rid", rs_id, 6'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("arb3_done", rs_valid, 0);
    check("mem16", smem[16], 32'h1234_5678);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
